// File: rtl/clock_ratio_monitor.sv
// clock_ratio_monitor
// Samples a divided clock in the 200 MHz domain and measures each half-period.
// Each measurement is checked against DIVIDE_BY +/- TOLERANCE. The block
// reports lock after LOCK_COUNT good halves in a row, and sets sticky flags
// for a ratio error while locked or for a stalled monitored clock.
module clock_ratio_monitor #(
    parameter int DIVIDE_BY  = 4,
    parameter int TOLERANCE  = 0,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 64,
    parameter int CNT_W      = 8
) (
    input  logic             clk_200M_i,
    input  logic             rstn_i,
    input  logic             en_i,
    input  logic             div_clk_i,
    input  logic             err_clr_i,
    output logic [CNT_W-1:0] half_period_o,
    output logic             valid_o,
    output logic             lock_o,
    output logic             err_o,
    output logic             timeout_o
);

    localparam int                 GOOD_W       = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [GOOD_W-1:0]  GOOD_LAST    = GOOD_W'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE, LOCKED} state_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // True when a measurement lies inside the accepted ratio window.
    function automatic logic in_tol(input logic [CNT_W-1:0] m);
        int mi;
        mi = int'(m);
        return (mi >= DIVIDE_BY - TOLERANCE) && (mi <= DIVIDE_BY + TOLERANCE);
    endfunction

    state_t             state_q, state_d;
    logic               s1_q, s2_q, s3_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GOOD_W-1:0]  good_q, good_d;
    logic [CNT_W-1:0]   half_q, half_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               to_q, to_d;

    logic               div_edge;
    logic [CNT_W-1:0]   meas;
    logic               tol_ok;
    logic               measure_ev;
    logic               timeout_ev;
    logic               err_set;
    logic               lock_reached;

    assign div_edge     = s2_q ^ s3_q;
    assign meas         = sat_inc(cnt_q);
    assign tol_ok       = in_tol(meas);
    // A measurement exists only when a previous edge gave a reference point.
    assign measure_ev   = en_i && div_edge && (state_q == MEASURE || state_q == LOCKED);
    // An edge in the same cycle takes priority over a timeout.
    assign timeout_ev   = en_i && !div_edge && (state_q != IDLE) && (cnt_q == TIMEOUT_LAST);
    assign err_set      = measure_ev && (state_q == LOCKED) && !tol_ok;
    assign lock_reached = measure_ev && (state_q == MEASURE) && tol_ok && (good_q == GOOD_LAST);

    // Two-flop synchronizer plus history flop for double-edge detection.
    always_ff @(posedge clk_200M_i) begin
        if (rstn_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= div_clk_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_200M_i) begin
        if (rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; disabling always wins.
    always_comb begin
        state_d = state_q;
        if (!en_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    state_d = ARM;
                ARM:     if (div_edge) state_d = MEASURE;
                MEASURE: begin
                    if (timeout_ev)        state_d = ARM;
                    else if (lock_reached) state_d = LOCKED;
                end
                LOCKED: begin
                    if (timeout_ev)   state_d = ARM;
                    else if (err_set) state_d = MEASURE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        lock_o = (state_q == LOCKED);
    end

    // Next values for the measurement counter, good-run counter and status.
    always_comb begin
        cnt_d   = sat_inc(cnt_q);
        good_d  = good_q;
        half_d  = half_q;
        valid_d = measure_ev;
        if (!en_i || state_q == IDLE) begin
            cnt_d  = '0;
            good_d = '0;
        end else if (div_edge) begin
            cnt_d = '0;
        end

        if (!en_i) begin
            half_d = '0;
        end else if (measure_ev) begin
            half_d = meas;
        end

        if (en_i && state_q != IDLE) begin
            if (timeout_ev) begin
                good_d = '0;
            end else if (measure_ev) begin
                if (!tol_ok)                good_d = '0;
                else if (state_q == MEASURE) good_d = good_q + GOOD_W'(1);
            end
        end

        // Setting a sticky flag beats a clear in the same cycle.
        err_d = err_set || (err_q && !err_clr_i);
        to_d  = timeout_ev || (to_q && !err_clr_i);
    end

    // Measurement and status registers.
    always_ff @(posedge clk_200M_i) begin
        if (rstn_i) begin
            cnt_q   <= '0;
            good_q  <= '0;
            half_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            good_q  <= good_d;
            half_q  <= half_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            to_q    <= to_d;
        end
    end

    assign half_period_o = half_q;
    assign valid_o       = valid_q;
    assign err_o         = err_q;
    assign timeout_o     = to_q;

endmodule

// File: tb/tb_clock_ratio_monitor.sv
// Bench for clock_ratio_monitor: two instances (TOLERANCE 0 and 1) share one
// directed stimulus. A timestamp-based model predicts every output each cycle;
// literal checks at key points pin the expected behaviour.
module tb_clock_ratio_monitor;

    logic       clk = 1'b0;
    logic       rst, en, div, clr;
    logic [7:0] hp0, hp1;
    logic       vl0, vl1, lk0, lk1, er0, er1, to0, to1;

    always #5 clk = ~clk;

    clock_ratio_monitor #(.DIVIDE_BY(4), .TOLERANCE(0), .LOCK_COUNT(4), .TIMEOUT(64), .CNT_W(8)) dut0 (
        .clk_200M_i(clk), .rstn_i(rst), .en_i(en), .div_clk_i(div), .err_clr_i(clr),
        .half_period_o(hp0), .valid_o(vl0), .lock_o(lk0), .err_o(er0), .timeout_o(to0));

    clock_ratio_monitor #(.DIVIDE_BY(4), .TOLERANCE(1), .LOCK_COUNT(4), .TIMEOUT(64), .CNT_W(8)) dut1 (
        .clk_200M_i(clk), .rstn_i(rst), .en_i(en), .div_clk_i(div), .err_clr_i(clr),
        .half_period_o(hp1), .valid_o(vl1), .lock_o(lk1), .err_o(er1), .timeout_o(to1));

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    int vcount = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Mode: 0 idle, 1 waiting for a first edge, 2 measuring, 3 locked.
    // Elapsed time is kept as a reference timestamp rather than a counter.
    int       md[2], good[2], rf[2];
    int       now = 0;
    bit [7:0] ehp[2];
    bit       evl[2], elk[2], eer[2], eto[2];
    bit       h1 = 0, h2 = 0, h3 = 0;

    always @(posedge clk) begin
        int el, m, tol;
        bit e, ok, se, st;
        now++;
        e = (h2 != h3);
        for (int k = 0; k < 2; k++) begin
            tol = (k == 0) ? 0 : 1;
            if (rst) begin
                md[k] = 0; good[k] = 0; ehp[k] = 0; evl[k] = 0;
                eer[k] = 0; eto[k] = 0; rf[k] = now;
            end else begin
                evl[k] = 0; se = 0; st = 0;
                if (!en) begin
                    md[k] = 0; good[k] = 0; ehp[k] = 0; rf[k] = now;
                end else if (md[k] == 0) begin
                    md[k] = 1; rf[k] = now;
                end else if (e) begin
                    el = now - rf[k];
                    rf[k] = now;
                    if (md[k] == 1) begin
                        md[k] = 2;
                    end else begin
                        m = (el > 255) ? 255 : el;
                        ehp[k] = m[7:0];
                        evl[k] = 1;
                        ok = (m >= 4 - tol) && (m <= 4 + tol);
                        if (md[k] == 2) begin
                            if (ok) begin
                                good[k]++;
                                if (good[k] == 4) md[k] = 3;
                            end else begin
                                good[k] = 0;
                            end
                        end else if (!ok) begin
                            se = 1; good[k] = 0; md[k] = 2;
                        end
                    end
                end else if (now - rf[k] == 64) begin
                    st = 1; good[k] = 0; md[k] = 1;
                end
                eer[k] = se | (eer[k] & !clr);
                eto[k] = st | (eto[k] & !clr);
            end
            elk[k] = (md[k] == 3);
        end
        if (rst) begin
            h1 = 0; h2 = 0; h3 = 0;
        end else begin
            h3 = h2; h2 = h1; h1 = div;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("hp0", hp0, ehp[0]);   check("hp1", hp1, ehp[1]);
            check("valid0", vl0, evl[0]); check("valid1", vl1, evl[1]);
            check("lock0", lk0, elk[0]);  check("lock1", lk1, elk[1]);
            check("err0", er0, eer[0]);   check("err1", er1, eer[1]);
            check("tmo0", to0, eto[0]);   check("tmo1", to1, eto[1]);
            vcount += int'(vl0) + int'(vl1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic half(input int n);
        div = ~div;
        cyc(n);
    endtask

    initial begin
        int vsnap;
        rst = 1; en = 0; div = 0; clr = 0;
        cyc(2);
        chk_en = 1;
        check("rst_hp", hp0, 0);  check("rst_valid", vl0, 0);
        check("rst_lock", lk0, 0); check("rst_err", er0, 0);
        check("rst_tmo", to0, 0);

        // Steady 4-cycle halves: first edge arms, four measurements lock.
        rst = 0; en = 1;
        cyc(2);
        repeat (5) half(4);
        check("lockA", lk0, 1); check("hpA", hp0, 4);
        check("errA", er0, 0);  check("tmoA", to0, 0);

        // One 5-cycle half while locked, then relock on four good halves.
        half(5);
        half(4);
        check("errB", er0, 1); check("lockB", lk0, 0); check("hpB", hp0, 5);
        repeat (4) half(4);
        check("relockB", lk0, 1); check("errB_kept", er0, 1);
        clr = 1; cyc(1); clr = 0; cyc(1);
        check("errB_clr", er0, 0);

        // Stall the divided clock while locked.
        cyc(70);
        check("tmoC", to0, 1); check("lockC", lk0, 0);
        vsnap = vcount;
        half(4);
        half(4);
        check("validC", vcount - vsnap, 2);
        check("hpC", hp0, 4);

        // Relock, then error edge coincident with the clear pulse.
        repeat (3) half(4);
        check("lockD", lk0, 1);
        half(5);
        div = ~div; cyc(2); clr = 1; cyc(1); clr = 0; cyc(3);
        check("errD_set_wins", er0, 1); check("lockD_drop", lk0, 0);
        check("tmoD_cleared", to0, 0);  check("hpD", hp0, 5);
        clr = 1; cyc(1); clr = 0;
        check("errD_clr", er0, 0);

        // Tolerance window of one cycle on dut1: halves 3,5,4,3 then 6.
        rst = 1; div = 0; cyc(2); rst = 0; cyc(2);
        half(3); half(5); half(4); half(3); half(6);
        check("lockE1", lk1, 1); check("hpE1", hp1, 3); check("errE1", er1, 0);
        half(4);
        check("errE1_set", er1, 1); check("lockE1_drop", lk1, 0); check("hpE1_6", hp1, 6);
        check("lockE0", lk0, 0); check("errE0", er0, 0);

        // Reset while locked.
        repeat (5) half(4);
        check("lockF0", lk0, 1); check("lockF1", lk1, 1);
        rst = 1; div = 0; cyc(1);
        check("rstF_hp", hp0, 0);   check("rstF_lock0", lk0, 0);
        check("rstF_lock1", lk1, 0); check("rstF_err1", er1, 0);
        rst = 0; cyc(2);

        // Disable while locked with err set: sticky flag survives.
        repeat (5) half(4);
        half(5);
        repeat (5) half(4);
        check("lockG", lk0, 1); check("errG", er0, 1);
        en = 0; vsnap = vcount; cyc(1);
        check("enG_lock0", lk0, 0); check("enG_lock1", lk1, 0);
        check("enG_hp", hp0, 0);    check("enG_err_kept", er0, 1);
        repeat (3) half(4);
        check("enG_no_valid", vcount - vsnap, 0);

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_ratio_monitor.md
# clock_ratio_monitor

Monitors the divided clock produced by the user-domain clock divider by sampling it in the 200 MHz source domain, measuring every half-period in source-clock cycles, and checking it against the expected ratio. It reports each measurement, raises lock after a run of in-tolerance half-periods, and flags sticky errors on ratio deviation or a stalled divided clock. It sits in the user domain beside the divider and drives status for software or a watchdog.

## Interface
- DIVIDE_BY, default 4: expected half-period of the monitored clock, in clk_200M_i cycles (≥2).
- TOLERANCE, default 0: allowed ± deviation in cycles from DIVIDE_BY.
- LOCK_COUNT, default 4: consecutive in-tolerance half-periods required for lock (≥1).
- TIMEOUT, default 64: cycles without a monitored edge before timeout (> DIVIDE_BY+TOLERANCE, < 2^CNT_W).
- CNT_W, default 8: measurement counter width.
- clk_200M_i  in  1  source clock. One clock; the whole block is synchronous to it.
- rstn_i  in  1  reset, synchronous, active-high.
- en_i  in  1  monitor enable; low forces IDLE.
- div_clk_i  in  1  monitored clock, treated as asynchronous data.
- err_clr_i  in  1  one-cycle pulse clearing err_o and timeout_o.
- half_period_o  out  CNT_W  last measured half-period, in cycles.
- valid_o  out  1  one-cycle pulse when half_period_o updates.
- lock_o  out  1  ratio locked.
- err_o  out  1  sticky: out-of-tolerance measurement while locked.
- timeout_o  out  1  sticky: no edge for TIMEOUT cycles while armed.

## Operation
- Input path: two-flop synchronizer s1→s2, history flop s3; edge = s2 XOR s3. Rising and falling edges both count.
- Counter cnt: cleared to 0 on edge; otherwise increments, saturating at 2^CNT_W−1. Measurement m = cnt+1 (saturating).
- In-tolerance: DIVIDE_BY−TOLERANCE ≤ m ≤ DIVIDE_BY+TOLERANCE.
- FSM states: IDLE, ARM, MEASURE, LOCKED.
  - IDLE: cnt, good-run counter held at 0. en_i=1 → ARM.
  - ARM: waits for first edge (no measurement; no prior reference). Edge → MEASURE.
  - MEASURE: each edge loads half_period_o=m, pulses valid_o. In-tolerance increments good; reaching LOCK_COUNT → LOCKED. Out-of-tolerance clears good, stays in MEASURE, no err.
  - LOCKED: lock_o=1. Each edge measures as above. Out-of-tolerance → err_o=1, good=0, → MEASURE.
  - Any non-IDLE state: cnt reaching TIMEOUT−1 without edge → timeout_o=1, good=0, → ARM (lock drops).
  - en_i=0 in any state → IDLE next cycle; sticky flags retained.
- err_clr_i clears both sticky flags; if a set condition occurs in the same cycle, set wins.
- Edge and timeout in the same cycle: edge wins, no timeout.

## Timing
- Reset: half_period_o=0, valid_o=0, lock_o=0, err_o=0, timeout_o=0, FSM=IDLE, s1/s2/s3=0, cnt=0, good=0.
- Synchronizer latency: a div_clk_i level first sampled at clock edge k causes edge in the cycle after edge k+1; half_period_o/valid_o/lock_o/err_o register at edge k+2.
- lock_o rises on the same clock edge as the valid_o pulse of the LOCK_COUNT-th good measurement; falls on the same edge as err_o set or timeout_o set, or one cycle after en_i drops.
- valid_o is exactly one cycle wide; never asserted in IDLE or ARM.
- Reset mid-operation overrides everything on the next edge, including pending edges and err_clr_i.

## Test plan
- Divider-rate input toggling every 4 cycles, defaults, en_i=1 → valid_o every 4 cycles with half_period_o=4; lock_o rises on 4th valid pulse; err_o, timeout_o stay 0.
- Locked, then one half-period of 5 cycles → half_period_o=5, err_o=1, lock_o=0; relock after 4 further good 4-cycle halves; err_o stays 1 until err_clr_i pulse.
- TOLERANCE=1, halves of 3,5,4,3 cycles → lock_o=1 after fourth; a 6-cycle half sets err_o.
- Locked, div_clk_i held constant → timeout_o=1 and lock_o=0 at cycle 64 after last edge; FSM in ARM; resume toggling → first edge no valid_o, second edge valid_o with half_period_o=4.
- err_clr_i coincident with error-causing edge → err_o remains 1; err_clr_i alone → err_o=0 next cycle.
- rstn_i asserted while locked, and en_i=0 while locked → all outputs reset values next cycle (en_i case: sticky flags kept); no valid_o while en_i=0.
